// File: rtl/priority_encoder_hs_pkg.sv
// enc_pkg: constants and types shared by the priority encoder and its interface.
//   N_DEF / W_DEF : default request count and code width (same as the 2-to-4 decoder)
//   state_t       : handshake FSM state (IDLE = nothing presented, HOLD = code presented)
package enc_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/priority_encoder_hs_if.sv
// priority_encoder_hs_if: request/handshake bundle between event sources,
// the priority encoder and a binary-indexed consumer.
//   req_in     : request pulses (one bit per line)
//   clr_all    : synchronous flush
//   code_ready : consumer accepts the presented code
//   code_out   : presented index
//   code_valid : code_out is valid
//   pending    : registered pending vector
//   collision  : one-cycle pulse, a request hit an already pending bit
// slave modport is the encoder side, master the source/consumer side.
interface priority_encoder_hs_if #(
  parameter int N = enc_pkg::N_DEF
) ();

  localparam int W = $clog2(N);

  logic [N-1:0] req_in;
  logic         clr_all;
  logic         code_ready;
  logic [W-1:0] code_out;
  logic         code_valid;
  logic [N-1:0] pending;
  logic         collision;

  modport slave (
    input  req_in,
    input  clr_all,
    input  code_ready,
    output code_out,
    output code_valid,
    output pending,
    output collision
  );

  modport master (
    output req_in,
    output clr_all,
    output code_ready,
    input  code_out,
    input  code_valid,
    input  pending,
    input  collision
  );

endinterface

// File: rtl/priority_encoder_hs_prio_index.sv
// prio_index: combinational priority pick over a request vector.
//   vec : candidate vector
//   idx : index of the winning bit (0 when vec is empty)
//   any : at least one bit of vec is set
// LSB_FIRST=1 gives bit 0 the highest priority, LSB_FIRST=0 gives bit N-1.
module prio_index #(
  parameter int N         = enc_pkg::N_DEF,
  parameter int W         = $clog2(N),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the lowest-priority end so the last hit is the winner.
  always_comb begin
    idx = '0;
    any = |vec;
    if (LSB_FIRST) begin
      for (int unsigned i = N; i > 0; i--) begin
        if (vec[i-1]) idx = W'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_hs.sv
// priority_encoder_hs: sequential N-to-log2(N) priority encoder with a
// valid/ready output handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : priority_encoder_hs_if.slave (req_in, clr_all, code_ready in;
//           code_out, code_valid, pending, collision out)
// Request pulses accumulate in a sticky pending vector; the highest-priority
// pending index is presented and held until accepted, and only the accepted
// bit is cleared. A new request on the accept cycle for the same bit wins
// over the clear.
module priority_encoder_hs
  import enc_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int W         = $clog2(N),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  priority_encoder_hs_if.slave  bus
);

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;
  logic         coll_q, coll_d;

  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         accept;
  logic [N-1:0] clr_mask;

  prio_index #(
    .N         (N),
    .W         (W),
    .LSB_FIRST (LSB_FIRST)
  ) u_prio_index (
    .vec (pending_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // code_ready only matters while a code is presented.
  assign accept   = valid_q & bus.code_ready;
  assign clr_mask = accept ? (N'(1) << code_q) : '0;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    valid_d   = valid_q;
    // Clear is applied before the OR so a same-cycle set keeps the bit.
    pending_d = (pending_q & ~clr_mask) | bus.req_in;
    coll_d    = |(bus.req_in & pending_q & ~clr_mask);

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          code_d  = pick_idx;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (bus.clr_all) begin
      pending_d = '0;
      coll_d    = 1'b0;
      code_d    = '0;
      valid_d   = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      coll_q    <= coll_d;
    end
  end

  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.pending    = pending_q;
  assign bus.collision  = coll_q;

endmodule

// File: tb/tb_priority_encoder_hs.sv
// tb_priority_encoder_hs: two encoders (LSB-first and MSB-first) driven with
// identical stimulus and checked every cycle against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_priority_encoder_hs;

  logic clk;
  logic rst_n;

  priority_encoder_hs_if #(.N(4)) if0 ();
  priority_encoder_hs_if #(.N(4)) if1 ();

  priority_encoder_hs #(.N(4), .LSB_FIRST(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  priority_encoder_hs #(.N(4), .LSB_FIRST(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  // shared stimulus
  logic [3:0] req;
  logic       clr;
  logic       rdy;

  assign if0.req_in = req;  assign if1.req_in = req;
  assign if0.clr_all = clr; assign if1.clr_all = clr;
  assign if0.code_ready = rdy; assign if1.code_ready = rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0] pend;
    logic [1:0] code;
    logic       valid;
    logic       coll;
  } mstate_t;

  function automatic int pick(input logic [3:0] p, input bit lsb);
    int best = 0;
    bit found = 0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (!lsb || !found) best = i;
        found = 1;
      end
    end
    return best;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [3:0] r,
                                   input logic c, input logic rd, input bit lsb);
    mstate_t n;
    int taken;
    n = s;
    if (c) return '0;
    taken = (s.valid && rd) ? (1 << s.code) : 0;
    n.pend = 4'((int'(s.pend) & ~taken) | int'(r));
    n.coll = ((int'(r) & int'(s.pend) & ~taken) != 0);
    if (s.valid) begin
      if (rd) n.valid = 1'b0;
    end else if (s.pend != 0) begin
      n.valid = 1'b1;
      n.code  = 2'(pick(s.pend, lsb));
    end
    return n;
  endfunction

  mstate_t m0 = '0;
  mstate_t m1 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= step(m0, req, clr, rdy, 1'b1);
      m1 <= step(m1, req, clr, rdy, 1'b0);
    end
  end

  // ---------------- compare / monitor process ----------------
  int acc0[$];
  int acc1[$];
  int coll_cnt = 0;

  always @(negedge clk) begin
    chk("d0.pending",   int'(if0.pending),    int'(m0.pend));
    chk("d0.code_valid",int'(if0.code_valid), int'(m0.valid));
    chk("d0.collision", int'(if0.collision),  int'(m0.coll));
    if (m0.valid) chk("d0.code_out", int'(if0.code_out), int'(m0.code));
    chk("d1.pending",   int'(if1.pending),    int'(m1.pend));
    chk("d1.code_valid",int'(if1.code_valid), int'(m1.valid));
    chk("d1.collision", int'(if1.collision),  int'(m1.coll));
    if (m1.valid) chk("d1.code_out", int'(if1.code_out), int'(m1.code));
    if (rst_n && if0.code_valid && rdy) acc0.push_back(int'(if0.code_out));
    if (rst_n && if1.code_valid && rdy) acc1.push_back(int'(if1.code_out));
    if (if0.collision) coll_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int base0, base1, cbase;

  initial begin
    rst_n = 1'b0; req = '0; clr = 1'b0; rdy = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(3);
    // 1: reset then idle
    chk("t1.valid",   int'(if0.code_valid), 0);
    chk("t1.pending", int'(if0.pending),    0);
    chk("t1.code",    int'(if0.code_out),   0);

    // 2: single request
    rdy = 1'b1; req = 4'b0100;
    tick(); req = '0;
    tick();
    chk("t2.valid", int'(if0.code_valid), 1);
    chk("t2.code0", int'(if0.code_out),   2);
    chk("t2.code1", int'(if1.code_out),   2);
    tick();
    chk("t2.valid_after", int'(if0.code_valid), 0);
    chk("t2.pend_after",  int'(if0.pending),    0);

    // 3: priority drain
    base0 = acc0.size(); base1 = acc1.size();
    req = 4'b1011;
    tick(); req = '0;
    ticks(8);
    chk("t3.count0", acc0.size() - base0, 3);
    chk("t3.count1", acc1.size() - base1, 3);
    if (acc0.size() - base0 == 3) begin
      chk("t3.d0[0]", acc0[base0],   0);
      chk("t3.d0[1]", acc0[base0+1], 1);
      chk("t3.d0[2]", acc0[base0+2], 3);
    end
    if (acc1.size() - base1 == 3) begin
      chk("t3.d1[0]", acc1[base1],   3);
      chk("t3.d1[1]", acc1[base1+1], 1);
      chk("t3.d1[2]", acc1[base1+2], 0);
    end

    // 4: stall and collision
    rdy = 1'b0; cbase = coll_cnt;
    req = 4'b0010;
    tick(); req = '0;
    ticks(4);
    chk("t4.held_valid", int'(if0.code_valid), 1);
    chk("t4.held_code",  int'(if0.code_out),   1);
    req = 4'b0010;
    tick(); req = '0;
    ticks(2);
    chk("t4.held_code2", int'(if0.code_out), 1);
    chk("t4.coll_pulses", coll_cnt - cbase, 1);
    rdy = 1'b1;
    tick();
    chk("t4.pend_after", int'(if0.pending), 0);
    ticks(2);

    // 5: set on the accept cycle
    rdy = 1'b0; req = 4'b0010;
    tick(); req = '0;
    tick();
    chk("t5.presented", int'(if0.code_out), 1);
    rdy = 1'b1; req = 4'b0010;
    tick(); req = '0; rdy = 1'b0;
    chk("t5.pend_kept", int'(if0.pending),    2);
    chk("t5.no_coll",   int'(if0.collision),  0);
    tick();
    chk("t5.revalid", int'(if0.code_valid), 1);
    chk("t5.recode",  int'(if0.code_out),   1);
    rdy = 1'b1;
    ticks(2);
    rdy = 1'b0;

    // 6: flush
    req = 4'b1111;
    tick(); req = '0;
    tick();
    chk("t6.allones0", int'(if0.code_out), 0);
    chk("t6.allones1", int'(if1.code_out), 3);
    clr = 1'b1; req = 4'b0001;
    tick(); clr = 1'b0; req = '0;
    chk("t6.flush_pend",  int'(if0.pending),    0);
    chk("t6.flush_valid", int'(if0.code_valid), 0);
    chk("t6.flush_pend1", int'(if1.pending),    0);

    // 6b: async reset mid-HOLD
    req = 4'b1111;
    tick(); req = '0;
    tick();
    chk("t6b.pre_valid", int'(if0.code_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6b.valid", int'(if0.code_valid), 0);
    chk("t6b.pend",  int'(if0.pending),    0);
    chk("t6b.code1", int'(if1.code_out),   0);
    chk("t6b.pend1", int'(if1.pending),    0);
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 29) == 0);
      tick();
    end
    req = '0; rdy = 1'b1; clr = 1'b0;
    ticks(12);
    chk("drain.pend0", int'(if0.pending), 0);
    chk("drain.pend1", int'(if1.pending), 0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
